// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running W-bit period counter with a registered
// wrap strobe that is high in the cycle where cnt has just rolled over to 0.
module pwm_period_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt + 1'b1;
            wrap <= &cnt;
        end
    end

endmodule

// File: rtl/pwm_modulator_core.sv
// pwm_modulator_core: fixed-period PWM; one pulse of setpoint*2^K clocks per
// 2^PWM_PERIOD_DIV period, setpoint sampled on the period-start strobe.
module pwm_modulator_core #(
    parameter int PWM_PERIOD_DIV = 16,
    parameter int MOD_WIDTH      = 9
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [MOD_WIDTH-1:0] mod_setpoint,
    output logic                 pwm_out,
    output logic                 start_strobe,
    output logic                 busy
);

    localparam int K = PWM_PERIOD_DIV - MOD_WIDTH;

    // A shift of at least one guarantees the longest pulse ends before the next strobe.
    generate
        if (PWM_PERIOD_DIV < MOD_WIDTH + 1) begin : g_bad_params
            $error("pwm_modulator_core: PWM_PERIOD_DIV must be >= MOD_WIDTH+1");
        end
    endgenerate

    logic [PWM_PERIOD_DIV-1:0] cnt;
    logic [PWM_PERIOD_DIV-1:0] hc;
    logic [PWM_PERIOD_DIV-1:0] hc_next;

    pwm_period_counter #(
        .W(PWM_PERIOD_DIV)
    ) u_period (
        .clk (clk),
        .nrst(nrst),
        .cnt (cnt),
        .wrap(start_strobe)
    );

    always_comb begin
        hc_next = start_strobe ? (PWM_PERIOD_DIV'(mod_setpoint) << K)
                : (hc != '0) ? hc - 1'b1 : hc;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hc      <= '0;
            pwm_out <= 1'b0;
            busy    <= 1'b0;
        end else begin
            hc      <= hc_next;
            pwm_out <= hc_next != '0;
            busy    <= hc_next != '0;
        end
    end

    // The pulse always sits strictly inside the period, clear of the wrap.
    a_pulse_inside_period: assert property (
        @(posedge clk) disable iff (!nrst) pwm_out |-> (cnt != '0 && cnt != '1)
    );

endmodule

// File: tb/tb_pwm_modulator_core.sv
// tb_pwm_modulator_core: directed scenarios on a 64-clock period (K = 1),
// each task checking its own expectations inline.
module tb_pwm_modulator_core;

    localparam int PD = 6;
    localparam int MW = 5;
    localparam int PERIOD = 64;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [MW-1:0] sp = '0;
    logic          pwm_out;
    logic          start_strobe;
    logic          busy;

    int total = 0;
    int passed = 0;

    pwm_modulator_core #(
        .PWM_PERIOD_DIV(PD),
        .MOD_WIDTH     (MW)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .mod_setpoint(sp),
        .pwm_out     (pwm_out),
        .start_strobe(start_strobe),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Counts edges until start_strobe is seen (0 if never within the bound).
    task automatic count_to_strobe(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (start_strobe === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Observes one period starting just after a strobe; loads next_sp when the next strobe shows.
    task automatic measure(input logic [MW-1:0] next_sp, input int chg_at,
                           input logic [MW-1:0] chg_val, output int width,
                           output int gaps, output int bmm, output int spos);
        bit low_seen;
        low_seen = 1'b0;
        width = 0;
        gaps = 0;
        bmm = 0;
        spos = 0;
        for (int i = 1; i <= PERIOD; i++) begin
            @(posedge clk);
            #1;
            if (i == chg_at) sp = chg_val;
            if (pwm_out !== busy) bmm++;
            if (pwm_out === 1'b1) begin
                width++;
                if (low_seen) gaps++;
            end else begin
                low_seen = 1'b1;
            end
            if (start_strobe === 1'b1 && spos == 0) begin
                spos = i;
                sp = next_sp;
            end
        end
    endtask

    task automatic test_reset();
        int n, w, g, b, s;
        nrst = 1'b0;
        sp = 5'd16;
        repeat (3) @(negedge clk);
        total++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm got %b want 0", pwm_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (start_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", start_strobe); else passed++;
        nrst = 1'b1;
        count_to_strobe(n);
        total++; if (n != 64) $display("FAIL first_strobe got %0d want 64", n); else passed++;
        for (int p = 0; p < 2; p++) begin
            measure(5'd16, 0, '0, w, g, b, s);
            total++; if (w != 32) $display("FAIL sp16_width p%0d got %0d want 32", p, w); else passed++;
            total++; if (g != 0) $display("FAIL sp16_gaps p%0d got %0d want 0", p, g); else passed++;
            total++; if (s != 64) $display("FAIL sp16_strobe p%0d got %0d want 64", p, s); else passed++;
            total++; if (b != 0) $display("FAIL sp16_busy p%0d got %0d want 0", p, b); else passed++;
        end
    endtask

    task automatic test_zero();
        int w, g, b, s;
        sp = 5'd0;
        for (int p = 0; p < 4; p++) begin
            measure(5'd0, 0, '0, w, g, b, s);
            total++; if (w != 0) $display("FAIL sp0_width p%0d got %0d want 0", p, w); else passed++;
            total++; if (s != 64) $display("FAIL sp0_strobe p%0d got %0d want 64", p, s); else passed++;
            total++; if (b != 0) $display("FAIL sp0_busy p%0d got %0d want 0", p, b); else passed++;
        end
    endtask

    task automatic test_max();
        int w, g, b, s;
        sp = 5'd31;
        for (int p = 0; p < 3; p++) begin
            measure(5'd31, 0, '0, w, g, b, s);
            total++; if (w != 62) $display("FAIL sp31_width p%0d got %0d want 62", p, w); else passed++;
            total++; if (g != 0) $display("FAIL sp31_gaps p%0d got %0d want 0", p, g); else passed++;
            total++; if (s != 64) $display("FAIL sp31_strobe p%0d got %0d want 64", p, s); else passed++;
        end
    endtask

    task automatic test_midchange();
        int w, g, b, s;
        sp = 5'd5;
        measure(5'd20, 5, 5'd20, w, g, b, s);
        total++; if (w != 10) $display("FAIL mid_cur_width got %0d want 10", w); else passed++;
        total++; if (s != 64) $display("FAIL mid_cur_strobe got %0d want 64", s); else passed++;
        measure(5'd20, 0, '0, w, g, b, s);
        total++; if (w != 40) $display("FAIL mid_next_width got %0d want 40", w); else passed++;
        total++; if (g != 0) $display("FAIL mid_next_gaps got %0d want 0", g); else passed++;
    endtask

    task automatic test_sine();
        logic [MW-1:0] tab [32];
        int w, g, b, s;
        tab = '{5'd16, 5'd19, 5'd22, 5'd24, 5'd27, 5'd29, 5'd30, 5'd31,
                5'd31, 5'd31, 5'd30, 5'd29, 5'd27, 5'd24, 5'd22, 5'd19,
                5'd16, 5'd13, 5'd10, 5'd8,  5'd5,  5'd3,  5'd2,  5'd1,
                5'd1,  5'd1,  5'd2,  5'd3,  5'd5,  5'd8,  5'd10, 5'd13};
        sp = tab[0];
        for (int j = 0; j < 32; j++) begin
            measure(tab[(j + 1) % 32], 0, '0, w, g, b, s);
            total++; if (w != 2 * int'(tab[j])) $display("FAIL sine_width j%0d got %0d want %0d", j, w, 2 * int'(tab[j])); else passed++;
            total++; if (b != 0 || s != 64) $display("FAIL sine_busy_strobe j%0d got busy_mm=%0d strobe=%0d want 0/64", j, b, s); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        sp = 5'd20;
        repeat (10) @(posedge clk);
        #1;
        total++; if (pwm_out !== 1'b1) $display("FAIL pre_reset_pwm got %b want 1", pwm_out); else passed++;
        #2 nrst = 1'b0;
        #1;
        total++; if (pwm_out !== 1'b0) $display("FAIL async_pwm got %b want 0", pwm_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL async_busy got %b want 0", busy); else passed++;
        @(posedge clk);
        #1;
        total++; if (pwm_out !== 1'b0) $display("FAIL held_pwm got %b want 0", pwm_out); else passed++;
        @(negedge clk);
        nrst = 1'b1;
        count_to_strobe(n);
        total++; if (n != 64) $display("FAIL strobe_after_reset got %0d want 64", n); else passed++;
        #1 nrst = 1'b0;
        #1;
        total++; if (start_strobe !== 1'b0) $display("FAIL async_strobe got %b want 0", start_strobe); else passed++;
        @(negedge clk);
        nrst = 1'b1;
        count_to_strobe(n);
        total++; if (n != 64) $display("FAIL strobe_after_reset2 got %0d want 64", n); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_midchange();
        test_sine();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
